result_demux_1to5: RTL and testbench
====================================

// Module: result_demux_1to5
// PURPOSE
//   Registered 1-to-5 distributor: inverse of the datapath's 32-bit 5-source select mux.
//   Takes one 32-bit result stream with a 3-bit destination select and steers each word to one of
//   five destination ports (A..E). Each destination has its own one-entry holding slot and a
//   valid/ready handshake, so a stalled consumer does not block words bound for the other ports.
//   Sits between the result producer (ALU/memory stage) and the five consumers of that result.
// PARAMETERS
//   DATA_W   32  data word width
//   CNT_W    16  width of the accepted-word and dropped-word counters
// PORTS
//   Clk          in   1         clock, rising edge
//   Rst_n        in   1         synchronous reset, active-low
//   in_data      in   DATA_W    word to distribute
//   in_sel       in   3         destination: 0=A 1=B 2=C 3=D 4=E; 5..7 are illegal
//   in_valid     in   1         in_data/in_sel are valid this cycle
//   in_ready     out  1         block accepts the word this cycle
//   out_data_x   out  DATA_W    x in {a,b,c,d,e}: held word for destination x
//   out_valid_x  out  1         slot x holds a word
//   out_ready_x  in   1         consumer x takes the word this cycle
//   err_sel      out  1         sticky: an illegal in_sel was accepted
//   acc_cnt      out  CNT_W     words delivered into slots, wraps modulo 2^CNT_W
//   drop_cnt     out  CNT_W     illegal-select words discarded, saturates at all-ones
// BEHAVIOUR
//   Reset (Rst_n=0 at a rising edge): all out_valid_x=0, out_data_x=0, err_sel=0, acc_cnt=0,
//     drop_cnt=0. Reset wins over every simultaneous event. A word held in a slot is lost.
//   Slot x state: EMPTY or FULL (1 bit, out_valid_x).
//     EMPTY -> FULL on a load; FULL -> EMPTY when out_ready_x=1 and there is no load that cycle.
//     FULL -> FULL with new data when out_ready_x=1 and a load happens in the same cycle (refill).
//   in_ready (combinational, no dependence on in_valid):
//     in_sel<=4: in_ready = !out_valid_x | out_ready_x, where x is the slot named by in_sel.
//     in_sel>=5: in_ready = 1 (the word is always accepted and discarded).
//   Accept = in_valid & in_ready. In the same edge:
//     legal select: slot x loads in_data; out_valid_x=1 on the next cycle (latency 1).
//       acc_cnt increments by 1.
//     illegal select: no slot changes; err_sel<=1; drop_cnt increments by 1 unless all-ones.
//   Only the addressed slot can load. Other slots drain independently in the same cycle.
//   out_data_x is stable while out_valid_x=1 and out_ready_x=0.
//   in_data and in_sel are ignored when in_valid=0. out_data_x keeps its last value after draining.
//   err_sel clears only on reset.
//   No combinational path from in_data to out_data_x. Combinational path out_ready_x -> in_ready
//     is allowed and required for full throughput.
// STRUCTURE
//   Shared package/header: NUM_DEST=5, SEL_W=3, SEL_A..SEL_E localparams, SEL_MAX=4.
//   Sub-module dest_slot: one-entry register with load, ready, data and valid;
//     instantiated 5 times with generate.
//   Top level holds the select decode, in_ready mux, counters and err_sel.
// TESTING
//   1 Reset: hold Rst_n=0 for 2 cycles with in_valid=1 -> all outputs 0.
//     After release with sel=0 and data=32'hDEADBEEF: out_valid_a=1 one cycle later.
//   2 Fan-out: sel 0..4 with data 1..5, all out_ready=1 -> each port sees its value exactly once,
//     one cycle after accept. acc_cnt=5.
//   3 Backpressure: out_ready_b=0, send two words to B -> the 2nd word stalls (in_ready=0).
//     A word sent to C in between passes. Raise out_ready_b -> the 2nd word arrives the next cycle.
//   4 Refill: slot D full with 32'h11, out_ready_d=1, same-cycle word 32'h22 to D -> in_ready=1.
//     Next cycle out_data_d=32'h22 and out_valid_d=1. acc_cnt counts both words.
//   5 Illegal select: sel=5,6,7 with in_valid=1 -> in_ready=1, no out_valid rises, err_sel=1,
//     drop_cnt=3. Preset drop_cnt near saturation -> it holds at all-ones.
//   6 Counter wrap and mid-stream reset: after 2^CNT_W accepts -> acc_cnt=0.
//     Assert Rst_n=0 while slots are full -> all slots empty and counters 0.

Source files
------------

// File: rtl/result_demux_1to5_pkg.sv
// ---------------------------------------------------------------------------
// result_demux_1to5_pkg
//   Shared constants and types for the 1-to-5 result distributor.
//   - destination count and select encoding (A..E = 0..4, 5..7 illegal)
//   - slot state encoding used by dest_slot
//   - sel_is_legal(): true for selects that name a real destination
// ---------------------------------------------------------------------------
package result_demux_1to5_pkg;

    localparam int NUM_DEST = 5;
    localparam int SEL_W    = 3;

    localparam logic [SEL_W-1:0] SEL_A   = 3'd0;
    localparam logic [SEL_W-1:0] SEL_B   = 3'd1;
    localparam logic [SEL_W-1:0] SEL_C   = 3'd2;
    localparam logic [SEL_W-1:0] SEL_D   = 3'd3;
    localparam logic [SEL_W-1:0] SEL_E   = 3'd4;
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_E;

    // One-entry slot: the state bit doubles as the slot's valid flag.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic sel_is_legal(input logic [SEL_W-1:0] sel);
        return (sel <= SEL_MAX);
    endfunction

endpackage

// File: rtl/result_demux_1to5_dest_slot.sv
// ---------------------------------------------------------------------------
// dest_slot
//   One-entry holding register for a single destination of result_demux_1to5.
//   Ports:
//     clk, rst_n     clock (rising edge), synchronous active-low reset
//     load           write load_data into the slot this edge (only when can_load)
//     load_data      word to store
//     out_ready      consumer takes the held word this cycle
//     can_load       slot can accept a word this cycle (empty, or draining)
//     out_data       held word; kept after draining
//     out_valid      slot is FULL (also serves as the slot state observation)
// ---------------------------------------------------------------------------
module dest_slot
    import result_demux_1to5_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              can_load,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    slot_state_e       state_q;
    slot_state_e       state_d;
    logic [DATA_W-1:0] data_q;

    // A full slot that is being drained this cycle can take a new word
    // in the same edge (refill), which keeps a streaming consumer at full rate.
    assign can_load  = (state_q == SLOT_EMPTY) | out_ready;
    assign out_valid = (state_q == SLOT_FULL);
    assign out_data  = data_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (load) begin
                    state_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                // Drain without refill empties the slot; drain with refill stays full.
                if (out_ready && !load) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                data_q <= load_data;
            end
        end
    end

endmodule

// File: rtl/result_demux_1to5.sv
// ---------------------------------------------------------------------------
// result_demux_1to5
//   Registered 1-to-5 distributor. Each input word is steered by in_sel into
//   one of five one-entry slots (A..E); each slot has its own handshake so a
//   stalled consumer only blocks words addressed to it. Illegal selects (5..7)
//   are always accepted and discarded, setting err_sel and counting drop_cnt.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. in_ready never looks at in_valid; out_valid_x never looks at
//   out_ready_x; out_data_x is held stable while out_valid_x=1 and
//   out_ready_x=0. in_ready depends combinationally on out_ready_x of the
//   addressed slot so a draining slot can be refilled in the same cycle.
//
//   Ports:
//     Clk, Rst_n               clock (rising edge), synchronous active-low reset
//     in_data, in_sel          word and destination (0=A .. 4=E, 5..7 illegal)
//     in_valid, in_ready       input handshake
//     out_data_x, out_valid_x  held word / slot full, x in a..e
//     out_ready_x              consumer x takes the word
//     err_sel                  sticky: an illegal select was accepted
//     acc_cnt                  words loaded into slots, wraps
//     drop_cnt                 illegal words discarded, saturates at all-ones
// ---------------------------------------------------------------------------
module result_demux_1to5
    import result_demux_1to5_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,

    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_valid,
    output logic              in_ready,

    output logic [DATA_W-1:0] out_data_a,
    output logic              out_valid_a,
    input  logic              out_ready_a,
    output logic [DATA_W-1:0] out_data_b,
    output logic              out_valid_b,
    input  logic              out_ready_b,
    output logic [DATA_W-1:0] out_data_c,
    output logic              out_valid_c,
    input  logic              out_ready_c,
    output logic [DATA_W-1:0] out_data_d,
    output logic              out_valid_d,
    input  logic              out_ready_d,
    output logic [DATA_W-1:0] out_data_e,
    output logic              out_valid_e,
    input  logic              out_ready_e,

    output logic              err_sel,
    output logic [CNT_W-1:0]  acc_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    logic [NUM_DEST-1:0] slot_load;
    logic [NUM_DEST-1:0] slot_can_load;
    logic [NUM_DEST-1:0] slot_valid;
    logic [NUM_DEST-1:0] slot_ready;
    logic [DATA_W-1:0]   slot_data [NUM_DEST];

    logic accept;
    logic sel_legal;

    assign slot_ready = {out_ready_e, out_ready_d, out_ready_c, out_ready_b, out_ready_a};
    assign sel_legal  = sel_is_legal(in_sel);
    assign accept     = in_valid & in_ready;

    // in_ready follows the addressed slot; an illegal select matches no slot
    // and keeps the default of 1 so the word is swallowed.
    always_comb begin
        in_ready = 1'b1;
        for (int i = 0; i < NUM_DEST; i++) begin
            if (in_sel == SEL_W'(i)) begin
                in_ready = slot_can_load[i];
            end
        end
    end

    // Only the addressed slot loads; all others keep draining on their own.
    always_comb begin
        slot_load = '0;
        for (int i = 0; i < NUM_DEST; i++) begin
            slot_load[i] = accept & sel_legal & (in_sel == SEL_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_DEST; g++) begin : g_slot
        dest_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (Clk),
            .rst_n     (Rst_n),
            .load      (slot_load[g]),
            .load_data (in_data),
            .out_ready (slot_ready[g]),
            .can_load  (slot_can_load[g]),
            .out_data  (slot_data[g]),
            .out_valid (slot_valid[g])
        );
    end

    assign out_data_a  = slot_data[SEL_A];
    assign out_data_b  = slot_data[SEL_B];
    assign out_data_c  = slot_data[SEL_C];
    assign out_data_d  = slot_data[SEL_D];
    assign out_data_e  = slot_data[SEL_E];
    assign out_valid_a = slot_valid[SEL_A];
    assign out_valid_b = slot_valid[SEL_B];
    assign out_valid_c = slot_valid[SEL_C];
    assign out_valid_d = slot_valid[SEL_D];
    assign out_valid_e = slot_valid[SEL_E];

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            err_sel  <= 1'b0;
            acc_cnt  <= '0;
            drop_cnt <= '0;
        end else if (accept) begin
            if (sel_legal) begin
                acc_cnt <= acc_cnt + 1'b1;
            end else begin
                err_sel <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_result_demux_1to5.sv
// ---------------------------------------------------------------------------
// tb_result_demux_1to5
//   Directed bench for result_demux_1to5. Counters are built 8 bits wide so
//   wrap and saturation are reached in a few hundred cycles.
// ---------------------------------------------------------------------------
module tb_result_demux_1to5;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    logic              Clk;
    logic              Rst_n;
    logic [DATA_W-1:0] in_data;
    logic [2:0]        in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data_a, out_data_b, out_data_c, out_data_d, out_data_e;
    logic              out_valid_a, out_valid_b, out_valid_c, out_valid_d, out_valid_e;
    logic              out_ready_a, out_ready_b, out_ready_c, out_ready_d, out_ready_e;
    logic              err_sel;
    logic [CNT_W-1:0]  acc_cnt;
    logic [CNT_W-1:0]  drop_cnt;

    int vectors    = 0;
    int miscompares = 0;

    result_demux_1to5 #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data_a  (out_data_a),
        .out_valid_a (out_valid_a),
        .out_ready_a (out_ready_a),
        .out_data_b  (out_data_b),
        .out_valid_b (out_valid_b),
        .out_ready_b (out_ready_b),
        .out_data_c  (out_data_c),
        .out_valid_c (out_valid_c),
        .out_ready_c (out_ready_c),
        .out_data_d  (out_data_d),
        .out_valid_d (out_valid_d),
        .out_ready_d (out_ready_d),
        .out_data_e  (out_data_e),
        .out_valid_e (out_valid_e),
        .out_ready_e (out_ready_e),
        .err_sel     (err_sel),
        .acc_cnt     (acc_cnt),
        .drop_cnt    (drop_cnt)
    );

    // clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // advance one edge; inputs are changed and outputs sampled 1 ns after it
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] vvec();
        return {out_valid_e, out_valid_d, out_valid_c, out_valid_b, out_valid_a};
    endfunction

    function automatic logic [31:0] data_of(input int i);
        case (i)
            0:       return out_data_a;
            1:       return out_data_b;
            2:       return out_data_c;
            3:       return out_data_d;
            default: return out_data_e;
        endcase
    endfunction

    task automatic set_ready(input logic [4:0] r);
        {out_ready_e, out_ready_d, out_ready_c, out_ready_b, out_ready_a} = r;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    initial begin
        // ---- 1: reset with in_valid held high ----
        Rst_n = 1'b0;
        set_ready(5'b00000);
        drive(1'b1, 3'd0, 32'hDEADBEEF);
        tick();
        tick();
        check("rst_valid", {27'd0, vvec()}, 32'd0);
        check("rst_data_a", out_data_a, 32'd0);
        check("rst_data_e", out_data_e, 32'd0);
        check("rst_err", {31'd0, err_sel}, 32'd0);
        check("rst_acc", {24'd0, acc_cnt}, 32'd0);
        check("rst_drop", {24'd0, drop_cnt}, 32'd0);
        Rst_n = 1'b1;
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b0, 3'd0, 32'd0);
        check("first_valid_a", {27'd0, vvec()}, 32'h01);
        check("first_data_a", out_data_a, 32'hDEADBEEF);
        check("first_acc", {24'd0, acc_cnt}, 32'd1);
        set_ready(5'b11111);
        tick();
        check("a_drained", {27'd0, vvec()}, 32'd0);

        // ---- 2: fan-out, one word to each destination ----
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'(i), 32'(i + 1));
            check("fan_ready", {31'd0, in_ready}, 32'd1);
            tick();
            check("fan_valid", {27'd0, vvec()}, 32'(1 << i));
            check("fan_data", data_of(i), 32'(i + 1));
        end
        drive(1'b0, 3'd0, 32'd0);
        tick();
        check("fan_drained", {27'd0, vvec()}, 32'd0);
        // 1 word from step 1 plus 5 here
        check("fan_acc", {24'd0, acc_cnt}, 32'd6);

        // ---- 3: backpressure on B, C passes meanwhile ----
        set_ready(5'b11101);
        drive(1'b1, 3'd1, 32'h0000_00B1);
        check("b1_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("b1_valid", {31'd0, out_valid_b}, 32'd1);
        drive(1'b1, 3'd1, 32'h0000_00B2);
        check("b2_stall", {31'd0, in_ready}, 32'd0);
        tick();
        check("b_hold", out_data_b, 32'h0000_00B1);
        drive(1'b1, 3'd2, 32'h0000_00C1);
        check("c1_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("c1_valid", {27'd0, vvec()}, 32'h06);
        check("c1_data", out_data_c, 32'h0000_00C1);
        drive(1'b1, 3'd1, 32'h0000_00B2);
        check("b2_still_stall", {31'd0, in_ready}, 32'd0);
        set_ready(5'b11111);
        check("b2_ready", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b0, 3'd0, 32'd0);
        check("b2_valid", {27'd0, vvec()}, 32'h02);
        check("b2_data", out_data_b, 32'h0000_00B2);
        tick();
        check("b_drained", {27'd0, vvec()}, 32'd0);
        check("bp_acc", {24'd0, acc_cnt}, 32'd9);

        // ---- 4: refill D in the draining cycle ----
        set_ready(5'b10111);
        drive(1'b1, 3'd3, 32'h11);
        tick();
        check("d11_data", out_data_d, 32'h11);
        set_ready(5'b11111);
        drive(1'b1, 3'd3, 32'h22);
        check("refill_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("refill_valid", {31'd0, out_valid_d}, 32'd1);
        check("refill_data", out_data_d, 32'h22);
        drive(1'b0, 3'd3, 32'h33);
        tick();
        check("d_drained", {31'd0, out_valid_d}, 32'd0);
        check("d_keeps_data", out_data_d, 32'h22);
        check("refill_acc", {24'd0, acc_cnt}, 32'd11);

        // ---- 5: illegal selects, with every slot stalled ----
        set_ready(5'b00000);
        for (int s = 5; s < 8; s++) begin
            drive(1'b1, 3'(s), 32'hBAD0_0000 + 32'(s));
            check("ill_ready", {31'd0, in_ready}, 32'd1);
            tick();
            check("ill_no_valid", {27'd0, vvec()}, 32'd0);
        end
        drive(1'b0, 3'd0, 32'd0);
        check("ill_err", {31'd0, err_sel}, 32'd1);
        check("ill_drop3", {24'd0, drop_cnt}, 32'd3);
        check("ill_acc_same", {24'd0, acc_cnt}, 32'd11);
        // 3 + 260 drops exceeds 255
        drive(1'b1, 3'd7, 32'd0);
        for (int k = 0; k < 260; k++) begin
            tick();
        end
        drive(1'b0, 3'd0, 32'd0);
        tick();
        check("drop_sat", {24'd0, drop_cnt}, 32'hFF);
        check("err_sticky", {31'd0, err_sel}, 32'd1);

        // ---- 6: acc_cnt wrap, then reset with full slots ----
        set_ready(5'b00001);
        drive(1'b1, 3'd0, 32'h5A5A_0000);
        for (int k = 0; k < 245; k++) begin
            tick();
        end
        drive(1'b0, 3'd0, 32'd0);
        check("acc_wrap", {24'd0, acc_cnt}, 32'd0);
        drive(1'b1, 3'd0, 32'h5A5A_0001);
        tick();
        check("acc_after_wrap", {24'd0, acc_cnt}, 32'd1);
        set_ready(5'b00000);
        tick();
        for (int i = 1; i < 5; i++) begin
            drive(1'b1, 3'(i), 32'h7700 + 32'(i));
            tick();
        end
        drive(1'b1, 3'd0, 32'hFFFF_FFFF);
        check("all_full", {27'd0, vvec()}, 32'h1F);
        check("full_ready", {31'd0, in_ready}, 32'd0);
        Rst_n = 1'b0;
        tick();
        check("mid_rst_valid", {27'd0, vvec()}, 32'd0);
        check("mid_rst_data_c", out_data_c, 32'd0);
        check("mid_rst_acc", {24'd0, acc_cnt}, 32'd0);
        check("mid_rst_drop", {24'd0, drop_cnt}, 32'd0);
        check("mid_rst_err", {31'd0, err_sel}, 32'd0);
        Rst_n = 1'b1;
        drive(1'b0, 3'd0, 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
